// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and FSM states for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  // Two's-complement magnitude; INT_MIN maps onto itself, read as unsigned 2^31.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned restoring divider: one quotient bit per enabled cycle, MSB first.
module div_core
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            en,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN:0]   shifted;
  logic            fits;

  // Dividend bits shift out of the quotient register into the partial remainder.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    fits    = (shifted >= {1'b0, dvs_q});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (en) begin
      quo_q <= {quo_q[XLEN-2:0], fits};
      rem_q <= fits ? XLEN'(shifted - {1'b0, dvs_q}) : shifted[XLEN-1:0];
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add / restoring steps on magnitudes,
// sign fix-up and special cases in the final state, fixed 33-cycle start-to-done latency.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            reg_write
);

  state_e state_q, state_d;
  logic   load, calc, fin;

  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   a_raw_q;
  logic [XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0] prod_q;
  logic              a_neg_q, b_neg_q, div_zero_q, div_ovf_q;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     psum;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo, rem, quo_fix, rem_fix, res_c;

  // Operand sign treatment depends on the op being issued.
  always_comb begin
    a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV)  || (funct3 == F3_REM);
    b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg    = a_signed & rs1_data[XLEN-1];
    b_neg    = b_signed & rs2_data[XLEN-1];
    a_mag    = abs_val(rs1_data, a_neg);
    b_mag    = abs_val(rs2_data, b_neg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    calc    = 1'b0;
    fin     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        calc = 1'b1;
        if (cnt_q == CNT_W'(ITER - 1)) state_d = S_FIN;
      end
      S_FIN: begin
        fin     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shift-add multiply: multiplier sits in the low half and shifts out as the product grows.
  assign psum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      op_q       <= F3_MUL;
      rd_q       <= '0;
      a_raw_q    <= '0;
      mcand_q    <= '0;
      prod_q     <= '0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
    end else if (load) begin
      cnt_q      <= '0;
      op_q       <= funct3;
      rd_q       <= rd_in;
      a_raw_q    <= rs1_data;
      mcand_q    <= a_mag;
      prod_q     <= {{XLEN{1'b0}}, b_mag};
      a_neg_q    <= a_neg;
      b_neg_q    <= b_neg;
      div_zero_q <= (rs2_data == '0);
      div_ovf_q  <= b_signed && (rs1_data == INT_MIN) && (rs2_data == '1);
    end else if (calc) begin
      cnt_q  <= cnt_q + CNT_W'(1);
      prod_q <= {psum, prod_q[XLEN-1:1]};
    end
  end

  div_core u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .en        (calc),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem)
  );

  // Sign fix-up and RISC-V special cases; unsigned ops carry clear sign flags.
  always_comb begin
    prod_fix = (a_neg_q ^ b_neg_q) ? -prod_q : prod_q;
    quo_fix  = (a_neg_q ^ b_neg_q) ? -quo : quo;
    rem_fix  = a_neg_q ? -rem : rem;
    res_c    = '0;
    case (op_q)
      F3_MUL:                      res_c = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res_c = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU: begin
        if (div_zero_q)     res_c = '1;
        else if (div_ovf_q) res_c = INT_MIN;
        else                res_c = quo_fix;
      end
      F3_REM, F3_REMU: begin
        if (div_zero_q)     res_c = a_raw_q;
        else if (div_ovf_q) res_c = '0;
        else                res_c = rem_fix;
      end
      default: res_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      reg_write <= 1'b0;
      result    <= '0;
      rd_out    <= '0;
    end else begin
      busy      <= (state_d != S_IDLE);
      done      <= fin;
      reg_write <= fin && (rd_q != '0);
      if (fin) begin
        result <= res_c;
        rd_out <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, overlap/back-to-back and
// mid-operation reset sequences, then randomized ops against an arithmetic reference.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        reg_write;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  muldiv_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .rd_in     (rd_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .reg_write (reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Architectural RV32M semantics using wide integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f3)
      3'b000: r = ua * ub;
      3'b001: r = (sa * sb) >>> 32;
      3'b010: r = (sa * ub) >>> 32;
      3'b011: r = longint'(64'(ua * ub) >> 32);
      3'b100: r = (b == 0) ? -1 : sa / sb;
      3'b101: r = (b == 0) ? -1 : ua / ub;
      3'b110: r = (b == 0) ? sa : sa % sb;
      default: r = (b == 0) ? ua : ua % ub;
    endcase
    return r[31:0];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, scramble the inputs after acceptance, wait (bounded) for done.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic rw,
                        output logic [4:0] ro, output int lat, output logic busy0);
    @(negedge clk);
    funct3 = f3; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    busy0    = busy;
    rs1_data = $urandom;
    rs2_data = $urandom;
    rd_in    = 5'($urandom);
    funct3   = 3'($urandom);
    lat = -1; res = result; rw = reg_write; ro = rd_out;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n; res = result; rw = reg_write; ro = rd_out;
        break;
      end
    end
  endtask

  task automatic do_check_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    logic [31:0] res;
    logic        rw, busy0;
    logic [4:0]  ro;
    int          lat;
    run_op(f3, a, b, rd, res, rw, ro, lat, busy0);
    check({name, " result"}, res, exp);
    check({name, " reg_write"}, 32'(rw), 32'(rd != 5'd0));
    check({name, " rd_out"}, 32'(ro), 32'(rd));
    check({name, " latency"}, 32'(lat), 32'd33);
    check({name, " busy_after_start"}, 32'(busy0), 32'd1);
  endtask

  initial begin
    int          lat, dones;
    logic [31:0] exp;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;

    rst = 1'b1; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset reg_write", 32'(reg_write), 32'd0);
    check("reset result", result, 32'd0);
    check("reset rd_out", 32'(rd_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
    vecs[1] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000};
    vecs[2] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE};
    vecs[3] = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd14, 32'hFFFF_FFFF};
    vecs[4] = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFD};
    vecs[5] = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFF};
    vecs[6] = '{3'b101, 32'd100,       32'h0000_0000, 5'd10, 32'hFFFF_FFFF};
    vecs[7] = '{3'b111, 32'd100,       32'h0000_0000, 5'd11, 32'd100};
    vecs[8] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000};
    vecs[9] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000};

    for (int i = 0; i < 10; i++) begin
      do_check_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d done_one_cycle", i), 32'(done), 32'd0);
      check($sformatf("vec%0d busy_after_done", i), 32'(busy), 32'd0);
    end

    // start re-asserted mid-operation with different operands must be ignored
    @(negedge clk);
    funct3 = 3'b100; rs1_data = 32'hFFFF_FF9C; rs2_data = 32'd7; rd_in = 5'd9; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (n == 9) begin
        start = 1'b1; funct3 = 3'b000; rs1_data = 32'd123; rs2_data = 32'd456; rd_in = 5'd0;
      end
      if (n == 12) start = 1'b0;
    end
    check("overlap result", result, ref_model(3'b100, 32'hFFFF_FF9C, 32'd7));
    check("overlap rd_out", 32'(rd_out), 32'd9);
    check("overlap reg_write", 32'(reg_write), 32'd1);
    check("overlap latency", 32'(lat), 32'd33);
    do_check_op("b2b_rd0", 3'b000, 32'd123, 32'd456, 5'd0, ref_model(3'b000, 32'd123, 32'd456));

    // asynchronous reset in the middle of DIVU 50/5
    @(negedge clk);
    funct3 = 3'b101; rs1_data = 32'd50; rs2_data = 32'd5; rd_in = 5'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst reg_write", 32'(reg_write), 32'd0);
    check("midrst result", result, 32'd0);
    check("midrst rd_out", 32'(rd_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done || reg_write) dones++;
    end
    check("midrst no_done", 32'(dones), 32'd0);
    do_check_op("post_rst_divu", 3'b101, 32'd50, 32'd5, 5'd3, 32'd10);

    for (int i = 0; i < 40; i++) begin
      f3  = 3'($urandom_range(0, 7));
      a   = pick_operand();
      b   = pick_operand();
      rd  = 5'($urandom_range(0, 31));
      exp = ref_model(f3, a, b);
      do_check_op($sformatf("rand%0d f3=%0d a=%08h b=%08h", i, f3, a, b), f3, a, b, rd, exp);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, downstream of the register file.
- Consumes the two register-file read operands plus the destination index, and computes over a fixed number of cycles.
- Returns a result with a write-enable and destination index, suitable for driving the register-file write port.
- Holds a busy signal so the issuing stage stalls while an operation is in flight.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iterations of the shift-add / restoring-divide loop; must equal XLEN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to begin an operation; sampled only in IDLE.
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  in  32  operand A (dividend / multiplicand), from register-file read_data1.
- rs2_data  in  32  operand B (divisor / multiplier), from register-file read_data2.
- rd_in  in  5  destination register index.
- busy  out  1  high from the cycle after start is accepted until the return to IDLE.
- done  out  1  one-cycle pulse; result is valid while done is high.
- result  out  32  final value; held until the next accepted start.
- rd_out  out  5  latched rd_in; held with result.
- reg_write  out  1  equals done AND (rd_out != 0).

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk.
- Reset values: state IDLE, busy=0, done=0, reg_write=0, result=0, rd_out=0, counter=0.
- Reset mid-operation aborts the operation with no done pulse and no write.
- States:
  - IDLE: start=1 at edge E0 latches funct3, rd_in and operand magnitudes plus sign flags; counter=0; next state CALC.
  - CALC: one iteration per edge at E1..E32; counter increments; at counter==31 next state FIN.
  - FIN (edge E33): apply sign correction and special cases, drive result; done=1 for exactly this cycle; next state IDLE at E34.
- busy=1 in CALC and FIN. start is ignored while busy; it must not corrupt the in-flight operation.
- Start-to-done latency is fixed at 33 cycles for every op, special cases included.
- Back-to-back: start may be raised in the cycle after FIN, i.e. the first IDLE cycle.
- Multiply:
  - 64-bit product computed on magnitudes; result negated if operand signs differ.
  - Sign treatment: MULH signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU and MUL unsigned.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- Divide/remainder:
  - Restoring division on magnitudes.
  - Quotient sign = sign(A) XOR sign(B) for DIV.
  - Remainder takes the sign of the dividend for REM.
- Divide by zero:
  - DIV/DIVU return 0xFFFFFFFF.
  - REM/REMU return rs1_data unchanged.
- Signed overflow (0x80000000 / 0xFFFFFFFF):
  - DIV returns 0x80000000.
  - REM returns 0.
- Operands are captured at E0; later changes on rs1_data, rs2_data or rd_in have no effect.
- rd_in == 0: done still pulses; reg_write stays 0.

Decomposition:
- Shared package muldiv_pkg:
  - funct3 localparams (F3_MUL..F3_REMU);
  - state encoding (S_IDLE, S_CALC, S_FIN);
  - XLEN constant.
- One natural sub-module: div_core, an unsigned restoring divider step (partial remainder, quotient shift, one iteration per enable). The multiply datapath and sign fix-up stay in muldiv_unit.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD), rd=5 -> done at E33, result=0xFFFFFFEB, reg_write=1, rd_out=5, busy low in the next cycle.
- MULH 0x80000000 x 0x80000000 -> result 0x40000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE.
- DIV -7 / 2 -> result 0xFFFFFFFD.
- REM -7 / 2 -> result 0xFFFFFFFF.
- DIVU 100 / 0 -> result 0xFFFFFFFF.
- REMU 100 / 0 -> result 100.
- DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000.
- REM with the same operands -> result 0.
- Start re-asserted at E10 with different operands and rd=0:
  - the first op completes unaffected at E33 with correct result;
  - a second op issued in the first IDLE cycle has rd=0 -> done=1, reg_write=0.
- rst pulsed at E15 during DIVU 50/5:
  - outputs return to 0 immediately (asynchronous), no done pulse, state IDLE;
  - a fresh DIVU 50/5 afterwards -> result 10 after 33 cycles.
